// File: rtl/sync_updown_counter.sv
// Synchronous up/down counter with programmable modulus, prescaler, parallel
// load and wrap/saturate mode. All state is on clk with synchronous reset.
module sync_updown_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MAX_VAL = 15,
   parameter int unsigned DIV     = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   // Prescaler width; one bit minimum so DIV=1 still has a legal vector.
   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [WIDTH-1:0] MaxQ  = WIDTH'(MAX_VAL);
   localparam logic [PW-1:0]    PLast = PW'(DIV - 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic             wrap_q, wrap_d;

   // Next state: load beats enable; a step happens on the last prescale slot.
   always_comb begin
      cnt_d  = cnt_q;
      pcnt_d = pcnt_q;
      wrap_d = 1'b0;
      if (load) begin
         cnt_d  = (load_val > MaxQ) ? MaxQ : load_val;
         pcnt_d = '0;
      end else if (en) begin
         if (pcnt_q == PLast) begin
            pcnt_d = '0;
            if (up) begin
               if (cnt_q >= MaxQ) begin
                  if (!sat) begin
                     cnt_d  = '0;
                     wrap_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end else begin
               if (cnt_q == '0) begin
                  if (!sat) begin
                     cnt_d  = MaxQ;
                     wrap_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - WIDTH'(1);
               end
            end
         end else begin
            pcnt_d = pcnt_q + PW'(1);
         end
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         pcnt_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pcnt_q <= pcnt_d;
         wrap_q <= wrap_d;
      end
   end

   // Terminal count follows q and direction without a register stage.
   always_comb begin
      tc = up ? (cnt_q == MaxQ) : (cnt_q == '0);
   end

   assign q    = cnt_q;
   assign wrap = wrap_q;

endmodule
